// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 decryption core.
// The key cache in aes_decrypt_top is enabled by defining AES_DEC_KEY_CACHE_EN.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } aes_dec_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Byte b = row + 4*col sits at bits [127-8b -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+4-row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box (combinational): inverse affine map followed by GF(2^8) inversion.
module aes_inv_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    assign out_byte = gf_inv(rotl8(in_byte, 1) ^ rotl8(in_byte, 3) ^ rotl8(in_byte, 6) ^ 8'h05);
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box (combinational), shared with the encryption core's key schedule.
module aes_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    logic [7:0] inv;

    assign inv      = gf_inv(in_byte);
    assign out_byte = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryption core, one inverse round per AES_clk edge.
// Define AES_DEC_KEY_CACHE_EN to skip key expansion when the key repeats.
module aes_decrypt_top
    import aes_dec_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy,
    output logic [2:0]   dbg_state
);
    // Handshake: AES_en is sampled only in IDLE; AES_data_out_valid is a one-cycle
    // pulse with no backpressure; AES_busy covers start edge through the DONE edge.
    aes_dec_state_e state_q, state_d;
    logic [3:0]     rcnt_q, rcnt_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   out_q, out_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic [127:0]   rk_q [0:10];
    logic [127:0]   rk_d [0:10];
`ifdef AES_DEC_KEY_CACHE_EN
    logic           cache_vld_q, cache_vld_d;
    logic [127:0]   cache_key_q, cache_key_d;
`endif

    logic [127:0] isr, isb, rk_prev, rk_next;
    logic [3:0]   prev_idx;
    logic [31:0]  rot_w, sub_w, kw0, kw1, kw2, kw3;

    // InvSubBytes(InvShiftRows(state)) is shared by ROUND and FINAL.
    assign isr = inv_shift_rows(data_q);
    for (genvar g = 0; g < 16; g++) begin : g_isb
        aes_inv_sbox u_inv_sbox (.in_byte(isr[127-8*g -: 8]), .out_byte(isb[127-8*g -: 8]));
    end

    assign prev_idx = (rcnt_q == 4'd0) ? 4'd0 : rcnt_q - 4'd1;
    assign rk_prev  = rk_q[prev_idx];
    assign rot_w    = {rk_prev[23:0], rk_prev[31:24]};
    for (genvar g = 0; g < 4; g++) begin : g_sb
        aes_sbox u_sbox (.in_byte(rot_w[31-8*g -: 8]), .out_byte(sub_w[31-8*g -: 8]));
    end
    assign kw0     = rk_prev[127:96] ^ sub_w ^ {rcon(rcnt_q), 24'h000000};
    assign kw1     = kw0 ^ rk_prev[95:64];
    assign kw2     = kw1 ^ rk_prev[63:32];
    assign kw3     = kw2 ^ rk_prev[31:0];
    assign rk_next = {kw0, kw1, kw2, kw3};

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        data_d  = data_q;
        out_d   = out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        rk_d    = rk_q;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_key_d = cache_key_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (AES_en) begin
                    busy_d = 1'b1;
                    data_d = AES_data_in;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_vld_q && (AES_key_in == cache_key_q)) begin
                        state_d = S_INIT;
                    end else begin
                        // The array is about to be overwritten, so the tag must drop now.
                        cache_vld_d = 1'b0;
                        rk_d[0]     = AES_key_in;
                        rcnt_d      = 4'd1;
                        state_d     = S_KEYEXP;
                    end
`else
                    rk_d[0] = AES_key_in;
                    rcnt_d  = 4'd1;
                    state_d = S_KEYEXP;
`endif
                end
            end
            S_KEYEXP: begin
                rk_d[rcnt_q] = rk_next;
                rcnt_d       = rcnt_q + 4'd1;
                if (rcnt_q == 4'd10) begin
                    state_d = S_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_vld_d = 1'b1;
                    cache_key_d = rk_q[0];
`endif
                end
            end
            S_INIT: begin
                data_d  = data_q ^ rk_q[10];
                rcnt_d  = 4'd9;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                data_d = inv_mix_columns(isb ^ rk_q[rcnt_q]);
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q == 4'd1) state_d = S_FINAL;
            end
            S_FINAL: begin
                out_d   = isb ^ rk_q[0];
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            data_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            data_q  <= data_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            rk_q    <= rk_d;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= cache_vld_d;
            cache_key_q <= cache_key_d;
`endif
        end
    end

    assign AES_data_out       = out_q;
    assign AES_data_out_valid = valid_q;
    assign AES_busy           = busy_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_aes_decrypt_top.sv
// Self-checking bench for aes_decrypt_top: FIPS-197 vectors, back-to-back starts,
// mid-operation reset and random encrypt/decrypt round trips (AES_DEC_KEY_CACHE_EN aware).
module tb_aes_decrypt_top;

    logic         AES_clk;
    logic         AES_rst_n;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_busy;
    logic [2:0]   dbg_state;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_top dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid),
        .AES_busy           (AES_busy),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        AES_clk = 1'b0;
        forever #5 AES_clk = ~AES_clk;
    end
    always @(posedge AES_clk) cyc++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q[$];
    int           lat_q[$];
    int           start_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_valid  = 0;
    bit           cache_vld_m = 1'b0;
    logic [127:0] cache_key_m = '0;
    logic [7:0]   sbox_t [256];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference AES encryption model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Brute-force inverse search, then the forward affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = 8'h63;
            for (int i = 0; i < 8; i++) begin
                s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            end
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [31:0] m_sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] m_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3,
                                 a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3,
                                 a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03),
                                 m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02)};
        end
        return r;
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [0:43];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = m_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r < 10; r++)
            s = m_mix(m_shift(m_sub(s))) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        s = m_shift(m_sub(s)) ^ {w[40], w[41], w[42], w[43]};
        return s;
    endfunction

    function automatic int model_latency(input logic [127:0] key);
        bit hit;
        hit = CACHE_EN && cache_vld_m && (key == cache_key_m);
        cache_vld_m = 1'b1;
        cache_key_m = key;
        return hit ? 11 : 21;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [127:0] key, input logic [127:0] ct,
                          input logic [127:0] pt, output int lat);
        @(negedge AES_clk);
        AES_en      = 1'b1;
        AES_key_in  = key;
        AES_data_in = ct;
        @(posedge AES_clk);
        #1;
        lat = model_latency(key);
        exp_q.push_back(pt);
        lat_q.push_back(lat);
        start_q.push_back(cyc);
        check_eq("busy_rise", AES_busy, 1);
    endtask

    task automatic scramble_inputs();
        @(negedge AES_clk);
        AES_data_in = rand128();
        AES_key_in  = rand128();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge AES_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("timeout_pending", 128'(exp_q.size()), 0);
            exp_q.delete();
            lat_q.delete();
            start_q.delete();
        end
        repeat (2) @(negedge AES_clk);
    endtask

    task automatic single_op(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
        int lat;
        launch(key, ct, pt, lat);
        @(negedge AES_clk);
        AES_en      = 1'b0;
        AES_data_in = rand128();
        AES_key_in  = rand128();
        wait_done(40);
    endtask

    // ---------------- output monitor / scoreboard ----------------
    initial begin : monitor
        logic [127:0] e;
        int           l;
        int           s0;
        bit           prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge AES_clk);
            if (!AES_rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v) begin
                    check_eq("valid_width", AES_data_out_valid, 0);
                    check_eq("busy_fall", AES_busy, 0);
                end
                prev_v = AES_data_out_valid;
                if (AES_data_out_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_valid", AES_data_out_valid, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        l  = lat_q.pop_front();
                        s0 = start_q.pop_front();
                        check_eq("data_out", AES_data_out, e);
                        check_eq("latency", 128'(cyc - s0), 128'(l));
                        check_eq("busy_at_valid", AES_busy, 1);
                    end
                end
            end
        end
    end

    // ---------------- main stimulus ----------------
    initial begin
        int lat;
        int seen;
        logic [127:0] k;
        logic [127:0] p;

        AES_rst_n   = 1'b0;
        AES_en      = 1'b0;
        AES_data_in = '0;
        AES_key_in  = '0;
        build_sbox();

        repeat (3) @(negedge AES_clk);
        check_eq("reset_data_out", AES_data_out, 0);
        check_eq("reset_valid", AES_data_out_valid, 0);
        check_eq("reset_busy", AES_busy, 0);
        check_eq("reset_state", dbg_state, 0);
        AES_rst_n = 1'b1;
        repeat (2) @(negedge AES_clk);

        // FIPS-197 vectors; the second C.1 run exercises the key cache when present.
        single_op(C1_KEY, C1_CT, C1_PT);
        single_op(C1_KEY, C1_CT, C1_PT);
        single_op(B_KEY, B_CT, B_PT);

        // AES_en held high with inputs changing while busy.
        for (int j = 0; j < 4; j++) begin
            k = rand128();
            p = rand128();
            launch(k, m_encrypt(k, p), p, lat);
            repeat (lat + 1) scramble_inputs();
        end
        @(negedge AES_clk);
        AES_en = 1'b0;
        wait_done(60);

        // Reset in the middle of an operation.
        launch(C1_KEY, C1_CT, C1_PT, lat);
        @(negedge AES_clk);
        AES_en = 1'b0;
        repeat (14) @(negedge AES_clk);
        AES_rst_n = 1'b0;
        #1;
        exp_q.delete();
        lat_q.delete();
        start_q.delete();
        cache_vld_m = 1'b0;
        check_eq("midrst_data_out", AES_data_out, 0);
        check_eq("midrst_valid", AES_data_out_valid, 0);
        check_eq("midrst_busy", AES_busy, 0);
        check_eq("midrst_state", dbg_state, 0);
        seen = n_valid;
        repeat (3) @(negedge AES_clk);
        AES_rst_n = 1'b1;
        repeat (30) @(negedge AES_clk);
        check_eq("no_valid_after_reset", 128'(n_valid), 128'(seen));
        single_op(C1_KEY, C1_CT, C1_PT);

        // Encrypt/decrypt round trips.
        for (int j = 0; j < 100; j++) begin
            k = rand128();
            p = rand128();
            single_op(k, m_encrypt(k, p), p);
            repeat ($urandom_range(0, 3)) @(negedge AES_clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
